// File: rtl/seg_scan_if.sv
// Bundle between application logic and the 8-digit scan controller.
// The master side supplies display contents and the load strobe.
// The slave side (the controller) returns the pin-level scan outputs.
interface seg_scan_if;
    logic [31:0] digits;
    logic [7:0]  digit_en;
    logic [7:0]  blink_mask;
    logic [7:0]  dp;
    logic        load;
    logic [7:0]  seg_an;
    logic [7:0]  seg_out0;
    logic [7:0]  seg_out1;
    logic        scan_tick;

    modport master (
        output digits, digit_en, blink_mask, dp, load,
        input  seg_an, seg_out0, seg_out1, scan_tick
    );

    modport slave (
        input  digits, digit_en, blink_mask, dp, load,
        output seg_an, seg_out0, seg_out1, scan_tick
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit, two-bus 7-segment display.
// Four slots; slot s lights digit s on seg_out1 and digit s+4 on seg_out0.
// Display contents are double-buffered so they only change on slot boundaries.
// Anodes stay dark for DEAD cycles at the start of every slot to avoid ghosting.
module seg_scan_ctrl #(
    parameter int SCAN_DIV    = 100000,
    parameter int DEAD        = 2000,
    parameter int BLINK_TICKS = 250
) (
    input  logic      clk,
    input  logic      rst_n,
    seg_scan_if.slave bus
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(SCAN_DIV - 2);
    localparam logic [CNT_W-1:0] DEAD_CNT = CNT_W'(DEAD);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TICKS - 1);

    typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} slot_t;

    slot_t            state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [BLK_W-1:0] blink_cnt_reg, blink_cnt_next;
    logic             blink_phase_reg, blink_phase_next;
    logic             slot_end;

    logic [31:0] pend_digits_reg, act_digits_reg;
    logic [7:0]  pend_en_reg, act_en_reg;
    logic [7:0]  pend_blink_reg, act_blink_reg;
    logic [7:0]  pend_dp_reg, act_dp_reg;

    logic [7:0]  seg_an_reg, seg_an_next;
    logic [7:0]  seg_out0_reg, seg_out0_next;
    logic [7:0]  seg_out1_reg, seg_out1_next;
    logic        scan_tick_reg;

    logic [7:0]       vis;
    logic [7:0][7:0]  seg_code;
    logic [2:0]       lo_idx, hi_idx;

    // BCD to segments a..g (bit 6 = a); codes 10..15 are blank.
    function automatic logic [6:0] dec7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    assign slot_end = (cnt_reg == CNT_LAST);

    // Per-digit visibility and full segment byte; a hidden digit drops its dp too.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_digit
            assign vis[gi] = act_en_reg[gi] & ~(act_blink_reg[gi] & blink_phase_reg);
            assign seg_code[gi] = vis[gi] ? {dec7(act_digits_reg[4*gi +: 4]), act_dp_reg[gi]}
                                          : 8'h00;
        end
    endgenerate

    // Next slot, prescaler and blink timing, plus the next pin values for the current slot.
    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg + CNT_W'(1);
        blink_cnt_next   = blink_cnt_reg;
        blink_phase_next = blink_phase_reg;
        lo_idx           = {1'b0, state_reg};
        hi_idx           = {1'b1, state_reg};
        seg_out1_next    = seg_code[lo_idx];
        seg_out0_next    = seg_code[hi_idx];
        seg_an_next      = 8'h00;

        if (slot_end) begin
            cnt_next = '0;
            case (state_reg)
                S0:      state_next = S1;
                S1:      state_next = S2;
                S2:      state_next = S3;
                default: state_next = S0;
            endcase
            if (blink_cnt_reg == BLK_LAST) begin
                blink_cnt_next   = '0;
                blink_phase_next = ~blink_phase_reg;
            end else begin
                blink_cnt_next = blink_cnt_reg + BLK_W'(1);
            end
        end

        // Segment buses already carry the slot value during dead time; only anodes wait.
        if (cnt_reg >= DEAD_CNT) begin
            seg_an_next[lo_idx] = vis[lo_idx];
            seg_an_next[hi_idx] = vis[hi_idx];
        end
    end

    // Slot state, prescaler and blink state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S0;
            cnt_reg         <= '0;
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
            scan_tick_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            blink_cnt_reg   <= blink_cnt_next;
            blink_phase_reg <= blink_phase_next;
            // Registered one cycle early so the pulse lines up with the last count.
            scan_tick_reg   <= (cnt_reg == CNT_PRE);
        end
    end

    // Double buffer: load fills pending; boundaries promote pending, or fresh inputs if load coincides.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_digits_reg <= '0;
            pend_en_reg     <= '0;
            pend_blink_reg  <= '0;
            pend_dp_reg     <= '0;
            act_digits_reg  <= '0;
            act_en_reg      <= '0;
            act_blink_reg   <= '0;
            act_dp_reg      <= '0;
        end else begin
            if (bus.load) begin
                pend_digits_reg <= bus.digits;
                pend_en_reg     <= bus.digit_en;
                pend_blink_reg  <= bus.blink_mask;
                pend_dp_reg     <= bus.dp;
            end
            if (slot_end) begin
                if (bus.load) begin
                    act_digits_reg <= bus.digits;
                    act_en_reg     <= bus.digit_en;
                    act_blink_reg  <= bus.blink_mask;
                    act_dp_reg     <= bus.dp;
                end else begin
                    act_digits_reg <= pend_digits_reg;
                    act_en_reg     <= pend_en_reg;
                    act_blink_reg  <= pend_blink_reg;
                    act_dp_reg     <= pend_dp_reg;
                end
            end
        end
    end

    // Pin registers, one clock behind the scan state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_an_reg   <= 8'h00;
            seg_out0_reg <= 8'h00;
            seg_out1_reg <= 8'h00;
        end else begin
            seg_an_reg   <= seg_an_next;
            seg_out0_reg <= seg_out0_next;
            seg_out1_reg <= seg_out1_next;
        end
    end

    assign bus.seg_an    = seg_an_reg;
    assign bus.seg_out0  = seg_out0_reg;
    assign bus.seg_out1  = seg_out1_reg;
    assign bus.scan_tick = scan_tick_reg;

endmodule
